misr_compactor: RTL and testbench

- Downstream consumer for the generated design-under-test's 350-bit concatenated output bus `y`.
- Each sampled cycle, it folds `y` to 32 bits and compresses the result into a multiple-input signature register (MISR) over a programmable capture window.
- It then presents the final signature over a valid/ready handshake.
- Used by the simulation-identity flow to compare two simulators' runs with a single 32-bit value per window.

---
 rtl/misr_compactor.sv | 154 +++++++++++++++
 tb/tb_misr_compactor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_compactor.sv
// MISR signature compactor: folds a wide output bus to 32 bits per sample.
// Optional toggle counter on qualifying samples via MISR_TOGGLE_CNT_EN.
module misr_compactor #(
   parameter int                 Y_WIDTH       = 350,
   parameter int                 SIG_WIDTH     = 32,
   parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
   parameter logic [SIG_WIDTH-1:0] SEED        = 32'hFFFFFFFF,
   parameter int                 SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [Y_WIDTH-1:0]   y,
   input  logic                 start,
   input  logic [15:0]          window_len,
   input  logic                 sample_en,
   output logic                 busy,
   output logic [15:0]          sample_cnt,
   output logic                 sig_valid,
   input  logic                 sig_ready,
   output logic [SIG_WIDTH-1:0] signature,
`ifdef MISR_TOGGLE_CNT_EN
   output logic [15:0]          toggle_cnt,
`endif
   output logic                 done
);

   localparam int NCH = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
   localparam int SW  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      HOLD
   } state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [15:0]            len_q;
   logic [SW-1:0]          settle_q;
   logic                   done_q;
   logic [NCH*SIG_WIDTH-1:0] ypad;
   logic [SIG_WIDTH-1:0]   fold;
   logic [SIG_WIDTH-1:0]   misr_nx;
   logic                   take;
   logic                   accept;
   logic                   last;

   // Zero-extend so the top chunk carries only the remaining bits.
   assign ypad = (NCH*SIG_WIDTH)'(y);

   always_comb begin
      fold = '0;
      for (int i = 0; i < NCH; i++)
         fold = fold ^ ypad[i*SIG_WIDTH +: SIG_WIDTH];
   end

   assign misr_nx = {signature[SIG_WIDTH-2:0], 1'b0}
                  ^ (signature[SIG_WIDTH-1] ? POLY : '0)
                  ^ fold;

   assign accept = (state == IDLE) && start;
   assign take   = (state == CAPTURE) && (len_q != 16'd0) && sample_en;
   assign last   = take && ((sample_cnt + 16'd1) == len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start)
               state_nx = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
         end
         SETTLE: begin
            if (settle_q <= SW'(1))
               state_nx = CAPTURE;
         end
         CAPTURE: begin
            if (len_q == 16'd0 || last)
               state_nx = HOLD;
         end
         HOLD: begin
            if (sig_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      sig_valid = 1'b0;
      unique case (state)
         IDLE:    ;
         SETTLE:  busy = 1'b1;
         CAPTURE: busy = 1'b1;
         HOLD: begin
            busy      = 1'b1;
            sig_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         signature  <= SEED;
         sample_cnt <= '0;
         len_q      <= '0;
         settle_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= (state == HOLD) && sig_ready;
         if (accept) begin
            signature  <= SEED;
            sample_cnt <= '0;
            len_q      <= window_len;
            settle_q   <= SW'(SETTLE_CYCLES);
         end else if (state == SETTLE) begin
            settle_q <= settle_q - SW'(1);
         end else if (take) begin
            signature  <= misr_nx;
            sample_cnt <= sample_cnt + 16'd1;
         end
      end
   end

   assign done = done_q;

`ifdef MISR_TOGGLE_CNT_EN
   logic [Y_WIDTH-1:0] prev_q;

   // First sample of a window has no predecessor to compare against.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q     <= '0;
         toggle_cnt <= '0;
      end else if (accept) begin
         toggle_cnt <= '0;
      end else if (take) begin
         prev_q <= y;
         if (sample_cnt != 16'd0 && y != prev_q && toggle_cnt != 16'hFFFF)
            toggle_cnt <= toggle_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_misr_compactor.sv
// Directed bench for misr_compactor with a MISR reference model
// and a queue of expected signatures.
module tb_misr_compactor;

   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [349:0] y = '0;
   logic         start = 1'b0;
   logic [15:0]  window_len = '0;
   logic         sample_en = 1'b0;
   logic         busy;
   logic [15:0]  sample_cnt;
   logic         sig_valid;
   logic         sig_ready = 1'b0;
   logic [31:0]  signature;
   logic         done;
`ifdef MISR_TOGGLE_CNT_EN
   logic [15:0]  toggle_cnt;
`endif

   int compared = 0;
   int mismatched = 0;

   logic [31:0] m_sig;
   logic [15:0] m_cnt;
   logic [15:0] m_len;
   logic [31:0] q_sig[$];
   logic [15:0] q_cnt[$];

   misr_compactor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .y          (y),
      .start      (start),
      .window_len (window_len),
      .sample_en  (sample_en),
      .busy       (busy),
      .sample_cnt (sample_cnt),
      .sig_valid  (sig_valid),
      .sig_ready  (sig_ready),
      .signature  (signature),
`ifdef MISR_TOGGLE_CNT_EN
      .toggle_cnt (toggle_cnt),
`endif
      .done       (done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mfold(input logic [349:0] v);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < 350; i++)
         f[i % 32] = f[i % 32] ^ v[i];
      return f;
   endfunction

   function automatic logic [31:0] mstep(input logic [31:0] s,
                                         input logic [31:0] f);
      logic [31:0] n;
      n = {s[30:0], 1'b0} ^ f;
      if (s[31])
         n = n ^ POLY;
      return n;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a window and step through the settle cycles into CAPTURE.
   task automatic do_start(input logic [15:0] len);
      window_len = len;
      start = 1'b1;
      m_sig = SEED;
      m_cnt = '0;
      m_len = len;
      tick();
      start = 1'b0;
      window_len = 16'hABCD;
      tick();
      tick();
      if (len == 16'd0) begin
         q_sig.push_back(SEED);
         q_cnt.push_back(16'd0);
      end
   endtask

   task automatic feed(input logic en, input logic [349:0] v);
      y = v;
      sample_en = en;
      if (en && m_cnt < m_len) begin
         m_sig = mstep(m_sig, mfold(v));
         m_cnt = m_cnt + 16'd1;
         if (m_cnt == m_len) begin
            q_sig.push_back(m_sig);
            q_cnt.push_back(m_cnt);
         end
      end
      tick();
      sample_en = 1'b0;
   endtask

   task automatic expect_sig(input string tag);
      int n;
      n = 0;
      while (!sig_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 64'(sig_valid), 64'd1);
      if (q_sig.size() == 0) begin
         check({tag, "_queue"}, 64'd0, 64'd1);
      end else begin
         check({tag, "_sig"}, 64'(signature), 64'(q_sig.pop_front()));
         check({tag, "_cnt"}, 64'(sample_cnt), 64'(q_cnt.pop_front()));
      end
   endtask

   task automatic handshake(input string tag);
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_vld"}, 64'(sig_valid), 64'd0);
      tick();
      check({tag, "_done_off"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [349:0] v;
      logic [349:0] va;
      logic [349:0] vb;
      logic [31:0] held;

      #12;
      rst_n = 1'b1;
      repeat (5) tick();
      check("rst_sig", 64'(signature), 64'(SEED));
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_vld", 64'(sig_valid), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cnt", 64'(sample_cnt), 64'd0);

      // Single zero sample; known constant as well as model.
      do_start(16'd1);
      check("settle_busy", 64'(busy), 64'd1);
      feed(1'b1, '0);
      check("zero_const", 64'(signature), 64'h FB3EE249);
      expect_sig("zero");
      handshake("zero");

      v = '0;
      v[0] = 1'b1;
      do_start(16'd1);
      feed(1'b1, v);
      check("one_const", 64'(signature), 64'h FB3EE248);
      expect_sig("one");
      handshake("one");

      v = '0;
      v[320] = 1'b1;
      do_start(16'd1);
      feed(1'b1, v);
      check("b320_const", 64'(signature), 64'h FB3EE248);
      expect_sig("b320");
      handshake("b320");

      // Gaps then backpressure.
      do_start(16'd4);
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 11; k++)
            v[k*32 +: 32] = $urandom;
         feed((i % 2 == 0) || (i == 5), v);
         if (i == 4)
            check("gap_not_yet", 64'(sig_valid), 64'd0);
      end
      check("gap_cnt", 64'(sample_cnt), 64'd4);
      held = signature;
      for (int i = 0; i < 10; i++) begin
         y = ~y;
         tick();
         check("bp_vld", 64'(sig_valid), 64'd1);
         check("bp_sig", 64'(signature), 64'(held));
      end
      expect_sig("gap");
      handshake("gap");

      do_start(16'd0);
      expect_sig("len0");
      check("len0_sig", 64'(signature), 64'(SEED));
      handshake("len0");

      // Start during CAPTURE must not restart the window.
      do_start(16'd3);
      feed(1'b1, {11{32'h1234_5678}});
      start = 1'b1;
      feed(1'b1, {11{32'h0F0F_00FF}});
      start = 1'b0;
      check("nostart_cnt", 64'(sample_cnt), 64'd2);
      feed(1'b1, {11{32'hDEAD_BEEF}});
      expect_sig("nostart");
      handshake("nostart");

      // Reset mid-window.
      do_start(16'd5);
      feed(1'b1, {11{32'hCAFE_F00D}});
      feed(1'b1, {11{32'h0000_0001}});
      rst_n = 1'b0;
      #2;
      check("arst_sig", 64'(signature), 64'(SEED));
      check("arst_cnt", 64'(sample_cnt), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_vld", 64'(sig_valid), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Start accepted in the done cycle.
      do_start(16'd1);
      feed(1'b1, '1);
      expect_sig("d1");
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
      check("d1_done", 64'(done), 64'd1);
      window_len = 16'd2;
      start = 1'b1;
      m_sig = SEED;
      m_cnt = '0;
      m_len = 16'd2;
      tick();
      start = 1'b0;
      check("dstart_busy", 64'(busy), 64'd1);
      tick();
      tick();
      feed(1'b1, {11{32'h5555_AAAA}});
      feed(1'b1, {11{32'h0123_4567}});
      expect_sig("dstart");
      handshake("dstart");

`ifdef MISR_TOGGLE_CNT_EN
      va = {11{32'hA5A5_0001}};
      vb = {11{32'h5A5A_0002}};
      do_start(16'd4);
      check("tog_clr", 64'(toggle_cnt), 64'd0);
      feed(1'b1, va);
      feed(1'b1, va);
      feed(1'b1, vb);
      feed(1'b1, va);
      expect_sig("tog");
      check("tog_cnt", 64'(toggle_cnt), 64'd2);
      handshake("tog");
`else
      va = '0;
      vb = '0;
`endif

      check("queue_empty", 64'(q_sig.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
